// File: rtl/tour_cmd_seq.sv
// Knight tour command sequencer: walks the stored tour of one-hot moves, issuing a
// vertical then a horizontal cmd_proc command per move, muxed against UART commands.
module tour_cmd_seq #(
  parameter int          NUM_MOVES  = 24,
  parameter int          IDX_W      = 5,
  parameter logic [7:0]  RESP_DONE  = 8'hA5,
  parameter logic [7:0]  RESP_PROG  = 8'h5A,
  parameter bit          FANFARE_EN = 1'b1,
  parameter logic [3:0]  ABORT_OP   = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic [2:0]       state_dbg
);

  // Handshake: cmd is valid while cmd_rdy is high; the consumer pulses clr_cmd_rdy
  // to take it, and later pulses send_resp once the command has been executed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             flag, flag_nxt;
  logic             abort, last_move;
  logic             v_south, h_west;
  logic [3:0]       v_sq, h_sq;
  logic [15:0]      vert_cmd, horz_cmd;

  assign abort     = cmd_rdy_UART && (cmd_UART[15:12] == ABORT_OP);
  assign last_move = (mv_indx == IDX_W'(NUM_MOVES - 1));

  // Lowest set bit of move wins; an empty move decodes to zero squares heading N/E.
  always_comb begin
    v_south = 1'b0;
    v_sq    = 4'd0;
    h_west  = 1'b0;
    h_sq    = 4'd0;
    if (move[0]) begin
      h_sq = 4'd1; v_sq = 4'd2;
    end else if (move[1]) begin
      h_west = 1'b1; h_sq = 4'd1; v_sq = 4'd2;
    end else if (move[2]) begin
      h_west = 1'b1; h_sq = 4'd2; v_sq = 4'd1;
    end else if (move[3]) begin
      h_west = 1'b1; h_sq = 4'd2; v_south = 1'b1; v_sq = 4'd1;
    end else if (move[4]) begin
      h_west = 1'b1; h_sq = 4'd1; v_south = 1'b1; v_sq = 4'd2;
    end else if (move[5]) begin
      h_sq = 4'd1; v_south = 1'b1; v_sq = 4'd2;
    end else if (move[6]) begin
      h_sq = 4'd2; v_south = 1'b1; v_sq = 4'd1;
    end else if (move[7]) begin
      h_sq = 4'd2; v_sq = 4'd1;
    end
  end

  assign vert_cmd = {4'h2, (v_south ? 8'h7F : 8'h00), v_sq};
  assign horz_cmd = {(FANFARE_EN ? 4'h3 : 4'h2), (h_west ? 8'h3F : 8'hBF), h_sq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
      flag    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mv_indx <= idx_nxt;
      flag    <= flag_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = mv_indx;
    flag_nxt  = flag;
    if (state != IDLE && abort) begin
      // Abort wins over any handshake arriving in the same cycle.
      state_nxt = IDLE;
      idx_nxt   = '0;
      flag_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: if (start_tour) begin
          state_nxt = VERT;
          idx_nxt   = '0;
          flag_nxt  = 1'b1;
        end
        VERT: if (clr_cmd_rdy) begin
          state_nxt = WAIT_V;
          flag_nxt  = 1'b0;
        end
        WAIT_V: if (send_resp) begin
          state_nxt = HORZ;
          flag_nxt  = 1'b1;
        end
        HORZ: if (clr_cmd_rdy) begin
          state_nxt = WAIT_H;
          flag_nxt  = 1'b0;
        end
        WAIT_H: if (send_resp) begin
          if (last_move) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            state_nxt = VERT;
            idx_nxt   = mv_indx + IDX_W'(1);
            flag_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          flag_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cmd     = vert_cmd;
    cmd_rdy = flag;
    if (state == IDLE) begin
      cmd     = cmd_UART;
      cmd_rdy = cmd_rdy_UART;
    end else if (state == HORZ || state == WAIT_H) begin
      cmd = horz_cmd;
    end
  end

  assign resp      = (state == IDLE || (state == WAIT_H && last_move)) ? RESP_DONE : RESP_PROG;
  assign tour_busy = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq: decode vector table, full ROM tour, abort, reset and
// passthrough sequences, plus a second instance with fanfare off and an 8-move tour.
module tb_tour_cmd_seq;

  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_tour, clr_cmd_rdy, send_resp, cmd_rdy_UART;
  logic [15:0]      cmd_UART;
  logic [7:0]       move, move_d, move_q;
  logic             use_rom;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd;
  logic             cmd_rdy, tour_busy;
  logic [7:0]       resp;
  logic [2:0]       state_dbg;

  logic             start2, clr2, send2;
  logic [7:0]       move2;
  logic [IDX_W-1:0] idx2;
  logic [15:0]      cmd2;
  logic             rdy2, busy2;
  logic [7:0]       resp2;
  logic [2:0]       st2;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [7:0]  mv;
    logic [15:0] ev;
    logic [15:0] eh;
  } vec_t;
  vec_t       vt[10];
  int         tour_b[24];
  logic [7:0] tour_rom[32];

  always #5 clk = ~clk;

  // Tour memory: move follows mv_indx by one clock.
  always @(posedge clk) move_q <= tour_rom[mv_indx];
  assign move = use_rom ? move_q : move_d;

  tour_cmd_seq #(.NUM_MOVES(24), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
    .tour_busy(tour_busy), .state_dbg(state_dbg)
  );

  tour_cmd_seq #(.NUM_MOVES(8), .IDX_W(IDX_W), .FANFARE_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_tour(start2), .move(move2), .mv_indx(idx2),
    .cmd_UART(16'h0000), .cmd_rdy_UART(1'b0), .cmd(cmd2), .cmd_rdy(rdy2),
    .clr_cmd_rdy(clr2), .send_resp(send2), .resp(resp2),
    .tour_busy(busy2), .state_dbg(st2)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic pulse_start(); start_tour = 1'b1; tick(); start_tour = 1'b0; endtask
  task automatic pulse_clr();   clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0; endtask
  task automatic pulse_send();  send_resp = 1'b1; tick(); send_resp = 1'b0; endtask

  // One move starting in VERT; optionally stops in WAIT_H before the final send_resp.
  task automatic run_move(input logic [15:0] ev, input logic [15:0] eh, input bit last,
                          input bit stop, input bit do_chk, input logic [IDX_W-1:0] exp_idx);
    tick();
    if (do_chk) begin
      chk("vert_cmd", 32'(cmd), 32'(ev));
      chk("vert_rdy", 32'(cmd_rdy), 32'd1);
      chk("vert_resp", 32'(resp), 32'h5A);
      chk("vert_idx", 32'(mv_indx), 32'(exp_idx));
    end
    pulse_clr();
    if (do_chk) chk("wait_v_rdy", 32'(cmd_rdy), 32'd0);
    pulse_send();
    if (do_chk) begin
      chk("horz_cmd", 32'(cmd), 32'(eh));
      chk("horz_rdy", 32'(cmd_rdy), 32'd1);
    end
    pulse_clr();
    if (do_chk) chk("wait_h_resp", 32'(resp), last ? 32'hA5 : 32'h5A);
    if (!stop) pulse_send();
  endtask

  initial begin
    vt[0] = {8'h01, 16'h2002, 16'h3BF1};
    vt[1] = {8'h02, 16'h2002, 16'h33F1};
    vt[2] = {8'h04, 16'h2001, 16'h33F2};
    vt[3] = {8'h08, 16'h27F1, 16'h33F2};
    vt[4] = {8'h10, 16'h27F2, 16'h33F1};
    vt[5] = {8'h20, 16'h27F2, 16'h3BF1};
    vt[6] = {8'h40, 16'h27F1, 16'h3BF2};
    vt[7] = {8'h80, 16'h2001, 16'h3BF2};
    vt[8] = {8'h0C, 16'h2001, 16'h33F2};
    vt[9] = {8'h00, 16'h2000, 16'h3BF0};
    for (int i = 0; i < 32; i++) tour_rom[i] = 8'h00;
    for (int i = 0; i < 24; i++) begin
      tour_b[i]   = (i * 3) % 8;
      tour_rom[i] = 8'd1 << tour_b[i];
    end

    rst_n = 1'b0; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cmd_rdy_UART = 1'b0; cmd_UART = 16'h0000; move_d = 8'h00; use_rom = 1'b0;
    start2 = 1'b0; clr2 = 1'b0; send2 = 1'b0; move2 = 8'h40;
    tick(); tick();
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_idx", 32'(mv_indx), 32'd0);
    chk("rst_busy", 32'(tour_busy), 32'd0);
    chk("rst_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_resp", 32'(resp), 32'hA5);
    rst_n = 1'b1;
    tick();

    // Decode table: one move each, then abort from WAIT_H.
    for (int v = 0; v < 10; v++) begin
      move_d = vt[v].mv;
      pulse_start();
      chk("tbl_busy", 32'(tour_busy), 32'd1);
      run_move(vt[v].ev, vt[v].eh, 1'b0, 1'b1, 1'b1, '0);
      cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
      tick();
      chk("abort_state", 32'(state_dbg), 32'd0);
      chk("abort_cmd", 32'(cmd), 32'hF000);
      chk("abort_rdy", 32'(cmd_rdy), 32'd1);
      chk("abort_resp", 32'(resp), 32'hA5);
      cmd_rdy_UART = 1'b0; cmd_UART = 16'h0000;
      tick();
    end

    // Abort from WAIT_V at mv_indx 3, coinciding with send_resp.
    use_rom = 1'b1;
    tick();
    pulse_start();
    for (int i = 0; i < 3; i++)
      run_move(vt[tour_b[i]].ev, vt[tour_b[i]].eh, 1'b0, 1'b0, 1'b0, IDX_W'(i));
    tick();
    pulse_start();
    chk("busy_start_idx", 32'(mv_indx), 32'd3);
    chk("busy_start_state", 32'(state_dbg), 32'd1);
    cmd_UART = 16'h2BF3; cmd_rdy_UART = 1'b1;
    tick();
    chk("uart_ignored_cmd", 32'(cmd), 32'(vt[tour_b[3]].ev));
    chk("uart_ignored_state", 32'(state_dbg), 32'd1);
    cmd_rdy_UART = 1'b0;
    pulse_clr();
    chk("wait_v_state", 32'(state_dbg), 32'd2);
    cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1; send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("abort_v_state", 32'(state_dbg), 32'd0);
    chk("abort_v_cmd", 32'(cmd), 32'hF000);
    chk("abort_v_rdy", 32'(cmd_rdy), 32'd1);
    chk("abort_v_resp", 32'(resp), 32'hA5);
    chk("abort_v_idx", 32'(mv_indx), 32'd0);
    cmd_rdy_UART = 1'b0; cmd_UART = 16'h0000;
    tick();

    // Full 24-move tour from the ROM.
    pulse_start();
    for (int i = 0; i < 24; i++)
      run_move(vt[tour_b[i]].ev, vt[tour_b[i]].eh, i == 23, 1'b0, 1'b1, IDX_W'(i));
    chk("tour_end_busy", 32'(tour_busy), 32'd0);
    chk("tour_end_resp", 32'(resp), 32'hA5);
    chk("tour_end_idx", 32'(mv_indx), 32'd0);

    // Asynchronous reset in WAIT_H at mv_indx 7.
    pulse_start();
    for (int i = 0; i < 8; i++)
      run_move(vt[tour_b[i]].ev, vt[tour_b[i]].eh, 1'b0, i == 7, 1'b0, IDX_W'(i));
    chk("pre_rst_state", 32'(state_dbg), 32'd4);
    chk("pre_rst_idx", 32'(mv_indx), 32'd7);
    cmd_UART = 16'h1234;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state_dbg), 32'd0);
    chk("midrst_idx", 32'(mv_indx), 32'd0);
    chk("midrst_busy", 32'(tour_busy), 32'd0);
    chk("midrst_cmd", 32'(cmd), 32'h1234);
    tick();
    rst_n = 1'b1;
    tick();

    // IDLE passthrough is combinational.
    cmd_UART = 16'h2BF3; cmd_rdy_UART = 1'b1;
    #1;
    chk("pass_cmd", 32'(cmd), 32'h2BF3);
    chk("pass_rdy", 32'(cmd_rdy), 32'd1);
    tick();
    cmd_rdy_UART = 1'b0; cmd_UART = 16'h0000;
    tick();

    // Second instance: fanfare off, 8-move tour, move 8'h40 throughout.
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("d2_vert", 32'(cmd2), 32'h27F1);
      chk("d2_idx", 32'(idx2), 32'(k));
      clr2 = 1'b1; tick(); clr2 = 1'b0;
      send2 = 1'b1; tick(); send2 = 1'b0;
      chk("d2_horz", 32'(cmd2), 32'h2BF2);
      clr2 = 1'b1; tick(); clr2 = 1'b0;
      chk("d2_resp", 32'(resp2), (k == 7) ? 32'hA5 : 32'h5A);
      send2 = 1'b1; tick(); send2 = 1'b0;
    end
    chk("d2_end_busy", 32'(busy2), 32'd0);
    chk("d2_end_idx", 32'(idx2), 32'd0);
    chk("d2_end_rdy", 32'(rdy2), 32'd0);
    chk("d2_end_state", 32'(st2), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
